// File: rtl/param_stream_pkg.sv
// Shared definitions for the parameter-ROM stream sequencer.
package param_stream_pkg;

  // FSM encoding kept as plain constants so older tools and netlists see fixed codes.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_FIN   = 2'd3;

  // Width needed to hold a count from 0 to depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/param_stream_fifo.sv
// First-word-fall-through FIFO with registered storage and an occupancy count.
module param_stream_fifo
  import param_stream_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head_data,
  output logic                          head_valid,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int CW = count_width(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next pointers and occupancy from this cycle's push/pop.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control flops with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage write.
  always_ff @(posedge clk) begin
    // NOTE: the data array is not reset; head_valid derives from count_q and masks stale words.
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

endmodule

// File: rtl/param_stream_ctrl.sv
// Sequences reads of a parameter ROM and delivers them as a lossless valid/ready stream.
module param_stream_ctrl
  import param_stream_pkg::*;
#(
  parameter int PRECISION    = 16,
  parameter int PARALLELISM  = 1,
  parameter int OUT_DEPTH    = 32,
  parameter int ROM_LATENCY  = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_WIDTH = 8,
  parameter int ADDR_WIDTH   = $clog2(OUT_DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [REPEAT_WIDTH-1:0]          cfg_repeat,
  output logic                             busy,
  output logic                             done,
  output logic [ADDR_WIDTH-1:0]            rom_addr,
  output logic                             rom_ce,
  input  logic [PRECISION*PARALLELISM-1:0] rom_q,
  output logic [PRECISION-1:0]             data_out [PARALLELISM],
  output logic                             data_out_valid,
  input  logic                             data_out_ready,
  output logic                             data_out_last
);

  localparam int DW  = PRECISION * PARALLELISM;
  localparam int CW  = count_width(FIFO_DEPTH);
  localparam int IFW = count_width(ROM_LATENCY);

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } entry_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [REPEAT_WIDTH-1:0] pass_q, pass_d;
  logic [REPEAT_WIDTH-1:0] rep_q, rep_d;
  logic [ROM_LATENCY-1:0]  slot_q, slot_d;
  logic [ROM_LATENCY-1:0]  slot_last_q, slot_last_d;

  logic [IFW-1:0] inflight;
  logic [CW-1:0]  fifo_count;
  logic           pop, push, issue, issue_last, credit_ok;
  entry_t         push_entry, head_entry;

  // Reads issued but not yet returned by the ROM.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) inflight = inflight + IFW'(slot_q[i]);
  end

  // A read may issue only if its word is guaranteed a FIFO slot on return.
  assign pop        = data_out_valid & data_out_ready;
  assign credit_ok  = (32'(fifo_count) + 32'(inflight) - 32'(pop)) < 32'(FIFO_DEPTH);
  assign issue      = (state_q == ST_RUN) && credit_ok;
  assign issue_last = issue && (addr_q == ADDR_WIDTH'(OUT_DEPTH - 1));

  // The slot exiting the tracker marks rom_q as valid this cycle.
  assign push            = slot_q[ROM_LATENCY-1];
  assign push_entry.last = slot_last_q[ROM_LATENCY-1];
  assign push_entry.data = rom_q;

  // FSM, address/pass counters and the issue-slot tracker.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pass_d      = pass_q;
    rep_d       = rep_q;
    slot_d      = ROM_LATENCY'({slot_q, issue});
    slot_last_d = ROM_LATENCY'({slot_last_q, issue_last});
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rep_d   = cfg_repeat;
          addr_d  = '0;
          pass_d  = '0;
          state_d = (cfg_repeat == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue) begin
          if (addr_q == ADDR_WIDTH'(OUT_DEPTH - 1)) begin
            addr_d = '0;
            if (pass_q == rep_q - REPEAT_WIDTH'(1)) state_d = ST_DRAIN;
            else                                    pass_d  = pass_q + REPEAT_WIDTH'(1);
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Finish once nothing is in flight and the final buffered beat leaves this cycle.
        if ((inflight == '0) && (32'(fifo_count) == 32'(pop))) state_d = ST_FIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer flops with synchronous reset; a reset abandons any job in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      pass_q      <= '0;
      rep_q       <= '0;
      slot_q      <= '0;
      slot_last_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pass_q      <= pass_d;
      rep_q       <= rep_d;
      slot_q      <= slot_d;
      slot_last_q <= slot_last_d;
    end
  end

  param_stream_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .head_valid(data_out_valid),
    .count     (fifo_count)
  );

  // Unpack the head word into the element array.
  always_comb begin
    for (int j = 0; j < PARALLELISM; j++) data_out[j] = head_entry.data[PRECISION*j +: PRECISION];
  end

  assign data_out_last = data_out_valid & head_entry.last;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_FIN);
  assign rom_ce        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign rom_addr      = addr_q;

endmodule

// File: tb/tb_param_stream_ctrl.sv
// Directed bench for param_stream_ctrl: small (4-beat, 2-element) and default-sized instances.
module tb_param_stream_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: OUT_DEPTH=4, PARALLELISM=2 ----------------
  logic        a_start, a_busy, a_done, a_ce, a_valid, a_ready, a_last;
  logic [7:0]  a_rep;
  logic [2:0]  a_addr;
  logic [31:0] a_rom_q = '0;
  logic [31:0] a_s1 = '0;
  logic [15:0] a_dout [2];

  param_stream_ctrl #(.OUT_DEPTH(4), .PARALLELISM(2)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .cfg_repeat(a_rep), .busy(a_busy), .done(a_done),
    .rom_addr(a_addr), .rom_ce(a_ce), .rom_q(a_rom_q), .data_out(a_dout),
    .data_out_valid(a_valid), .data_out_ready(a_ready), .data_out_last(a_last)
  );

  // Two-stage ROM model: element0 = 0x1000+addr, element1 = 0x2000+addr.
  always @(posedge clk) begin
    if (a_ce) begin
      a_s1    <= {16'h2000 + 16'(a_addr), 16'h1000 + 16'(a_addr)};
      a_rom_q <= a_s1;
    end
  end

  // ---------------- instance B: defaults (OUT_DEPTH=32) ----------------
  logic        b_start, b_busy, b_done, b_ce, b_valid, b_ready, b_last;
  logic [7:0]  b_rep;
  logic [5:0]  b_addr;
  logic [15:0] b_rom_q = '0;
  logic [15:0] b_s1 = '0;
  logic [15:0] b_dout [1];

  param_stream_ctrl dut_b (
    .clk(clk), .rst(rst), .start(b_start), .cfg_repeat(b_rep), .busy(b_busy), .done(b_done),
    .rom_addr(b_addr), .rom_ce(b_ce), .rom_q(b_rom_q), .data_out(b_dout),
    .data_out_valid(b_valid), .data_out_ready(b_ready), .data_out_last(b_last)
  );

  always @(posedge clk) begin
    if (b_ce) begin
      b_s1    <= 16'h1000 + 16'(b_addr);
      b_rom_q <= b_s1;
    end
  end

  // ---------------- monitors (sample mid-low-phase, after inputs settle) ----------------
  logic [32:0] a_beats [$];
  logic [32:0] a_head_prev;
  logic        a_hold_prev = 1'b0;
  int a_first_v, a_hs_cyc, a_done_cyc, a_done_n, a_ce_n, a_valid_n;
  int a_stab_err = 0;

  always @(negedge clk) begin
    #2;
    if (!rst && a_hold_prev && (!a_valid || {a_last, a_dout[1], a_dout[0]} !== a_head_prev))
      a_stab_err++;
    a_hold_prev = !rst && a_valid && !a_ready;
    a_head_prev = {a_last, a_dout[1], a_dout[0]};
    if (a_valid && a_ready) begin
      a_beats.push_back({a_last, a_dout[1], a_dout[0]});
      a_hs_cyc = cyc;
    end
    if (a_valid) begin
      a_valid_n++;
      if (a_first_v < 0) a_first_v = cyc;
    end
    if (a_done) begin
      a_done_n++;
      a_done_cyc = cyc;
    end
    if (a_ce) a_ce_n++;
  end

  logic [16:0] b_beats [$];
  int b_done_n = 0;
  int b_last_n = 0;

  always @(negedge clk) begin
    #2;
    if (b_valid && b_ready) begin
      b_beats.push_back({b_last, b_dout[0]});
      if (b_last) b_last_n++;
    end
    if (b_done) b_done_n++;
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_a();
    a_beats.delete();
    a_first_v = -1;
    a_done_n  = 0;
    a_valid_n = 0;
    a_ce_n    = 0;
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    int n = 0;
    while (!a_done && n < budget) begin
      step();
      n++;
    end
    check(tag, a_done, 1'b1);
  endtask

  // Beat i of a 4-beat pass carries address i%4; last on address 3.
  task automatic check_seq_a(input string tag, input int n);
    check({tag, "_count"}, a_beats.size(), n);
    for (int i = 0; i < n && i < a_beats.size(); i++) begin
      logic [32:0] exp;
      exp = {(i % 4) == 3, 16'h2000 + 16'(i % 4), 16'h1000 + 16'(i % 4)};
      check($sformatf("%s_beat%0d", tag, i), a_beats[i], exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s;
    int n;

    rst = 1'b1;
    a_start = 1'b0; a_rep = '0; a_ready = 1'b1;
    b_start = 1'b0; b_rep = '0; b_ready = 1'b1;
    clear_a();
    repeat (3) step();

    // Reset state.
    check("rst_valid", a_valid, 1'b0);
    check("rst_busy",  a_busy,  1'b0);
    check("rst_done",  a_done,  1'b0);
    check("rst_ce",    a_ce,    1'b0);
    check("rst_addr",  a_addr,  3'd0);
    check("rst_last",  a_last,  1'b0);
    rst = 1'b0;
    step();

    // Two passes with ready held high.
    clear_a();
    a_rep = 8'd2; a_start = 1'b1; s = cyc;
    step();
    a_start = 1'b0;
    wait_done_a("t1_done_seen", 100);
    step();
    check("t1_busy_after_done", a_busy, 1'b0);
    check("t1_first_valid_lat", a_first_v - s, 4);
    check("t1_done_after_hs",   a_done_cyc - a_hs_cyc, 1);
    check("t1_done_pulses",     a_done_n, 1);
    check_seq_a("t1", 8);

    // Backpressure: ready low for cycles 5..12 after start.
    clear_a();
    a_rep = 8'd2; a_start = 1'b1; s = cyc;
    step();
    a_start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      a_ready = (k < 5);
      if (k == 8)  check("t2_addr_held_c8",  a_addr, 3'd1);
      if (k == 12) begin
        check("t2_addr_held_c12", a_addr, 3'd1);
        check("t2_valid_stalled", a_valid, 1'b1);
        check("t2_head_stalled",  {a_last, a_dout[1], a_dout[0]}, {1'b0, 16'h2001, 16'h1001});
      end
      step();
    end
    a_ready = 1'b1;
    wait_done_a("t2_done_seen", 100);
    step();
    check("t2_done_pulses", a_done_n, 1);
    check("t2_head_stable", a_stab_err, 0);
    check_seq_a("t2", 8);

    // Zero passes.
    clear_a();
    a_rep = 8'd0; a_start = 1'b1;
    step();
    a_start = 1'b0;
    check("t3_done_next_cycle", a_done, 1'b1);
    check("t3_busy_in_done",    a_busy, 1'b1);
    check("t3_ce_low",          a_ce,   1'b0);
    step();
    check("t3_busy_after", a_busy, 1'b0);
    repeat (5) step();
    check("t3_no_valid",    a_valid_n, 0);
    check("t3_no_ce",       a_ce_n,    0);
    check("t3_done_pulses", a_done_n,  1);

    // start held high: ignored while busy, re-accepted in IDLE after done.
    clear_a();
    a_rep = 8'd1; a_start = 1'b1;
    step();
    wait_done_a("t4_done1_seen", 100);
    check("t4_beats_job1", a_beats.size(), 4);
    step();
    check("t4_idle_after_done", a_busy, 1'b0);
    check("t4_one_done",        a_done_n, 1);
    step();
    a_start = 1'b0;
    check("t4_second_job_busy", a_busy, 1'b1);
    wait_done_a("t4_done2_seen", 100);
    step();
    check("t4_two_dones", a_done_n, 2);
    check_seq_a("t4", 8);

    // Reset mid-RUN with three beats buffered (ready low from the start).
    clear_a();
    a_ready = 1'b0; a_rep = 8'd2; a_start = 1'b1;
    step();
    a_start = 1'b0;
    repeat (5) step();
    check("t5_valid_before_rst", a_valid, 1'b1);
    check("t5_busy_before_rst",  a_busy,  1'b1);
    rst = 1'b1;
    step();
    check("t5_rst_valid", a_valid, 1'b0);
    check("t5_rst_busy",  a_busy,  1'b0);
    check("t5_rst_done",  a_done,  1'b0);
    check("t5_rst_ce",    a_ce,    1'b0);
    check("t5_rst_addr",  a_addr,  3'd0);
    rst = 1'b0; a_ready = 1'b1;
    repeat (3) step();
    check("t5_no_done_after_rst", a_done_n, 0);
    clear_a();
    a_rep = 8'd1; a_start = 1'b1;
    step();
    a_start = 1'b0;
    wait_done_a("t5_done_seen", 100);
    step();
    check_seq_a("t5", 4);

    // Default-sized instance, three passes, random backpressure.
    b_rep = 8'd3; b_start = 1'b1;
    step();
    b_start = 1'b0;
    n = 0;
    while (!b_done && n < 3000) begin
      b_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    check("t6_done_seen", b_done, 1'b1);
    b_ready = 1'b1;
    repeat (2) step();
    check("t6_busy_after", b_busy, 1'b0);
    check("t6_count", b_beats.size(), 96);
    for (int i = 0; i < 96 && i < b_beats.size(); i++)
      check($sformatf("t6_beat%0d", i), b_beats[i], {(i % 32) == 31, 16'h1000 + 16'(i % 32)});
    check("t6_last_flags",  b_last_n, 3);
    check("t6_done_pulses", b_done_n, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_stream_ctrl.md
Name: param_stream_ctrl

Overview:
- Sequencer for one synthesised parameter ROM (weights/bias), 2-cycle read latency, clock-enable input.
- Issues ROM addresses 0..OUT_DEPTH-1, repeated cfg_repeat times per job.
- Buffers ROM output in a small credit-managed FIFO, so the downstream valid/ready stream is lossless under backpressure.
- Sits between the ROM and the consuming linear/add stage; replaces a free-running counter with valid tied high.

Parameters:
- PRECISION, 16, bits per element.
- PARALLELISM, 1, elements per beat (product of dim-0 and dim-1 parallelism).
- OUT_DEPTH, 32, beats per pass (tensor size / parallelism).
- ROM_LATENCY, 2, cycles from rom_addr/rom_ce to rom_q; fixed by the ROM wrapper.
- FIFO_DEPTH, 4, output buffer entries; must be at least ROM_LATENCY+1.
- REPEAT_WIDTH, 8, width of the pass counter.
- ADDR_WIDTH, $clog2(OUT_DEPTH)+1, ROM address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  job start pulse; honoured only in IDLE.
- cfg_repeat  in  REPEAT_WIDTH  number of passes; sampled on an accepted start.
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse at job completion.
- rom_addr  out  ADDR_WIDTH  ROM read address.
- rom_ce  out  1  ROM clock enable.
- rom_q  in  PRECISION*PARALLELISM  ROM data, packed; element j is bits [PRECISION*j +: PRECISION].
- data_out  out  PRECISION x [PARALLELISM]  unpacked element array.
- data_out_valid  out  1  beat valid.
- data_out_ready  in  1  downstream accept.
- data_out_last  out  1  high on the final beat of each pass.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; FIFO is emptied; in-flight tracker is cleared.
  - busy, done, data_out_valid, data_out_last, rom_ce all 0; rom_addr 0.
  - Reset mid-job discards all buffered and in-flight data. No done is produced.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE: start=1 latches cfg_repeat, clears addr and pass counters, then moves to RUN. If cfg_repeat=0, it moves to FIN instead; no beats are emitted.
  - RUN: issues reads. When the read for addr OUT_DEPTH-1 of the last pass is issued, moves to DRAIN.
  - DRAIN: no new reads. When in-flight=0, the FIFO is empty, and the final beat handshakes, moves to FIN.
  - FIN: done=1 for one cycle, then back to IDLE.
  - start outside IDLE is ignored.
- ROM pipeline:
  - rom_ce=1 in RUN and DRAIN, 0 otherwise. The ROM pipeline advances every busy cycle.
  - A ROM_LATENCY-deep shift register tracks issue slots: bit = 1 when a read was issued that cycle. It also carries the last flag.
  - When a slot exits, rom_q is written into the FIFO in that cycle.
- Issue (credit) rule:
  - A read issues in RUN iff fifo_count + inflight - pop < FIFO_DEPTH, where pop = valid & ready this cycle.
  - On issue: rom_addr increments. It wraps from OUT_DEPTH-1 to 0, and the pass counter increments on wrap.
  - rom_addr holds when no read issues.
- Latency:
  - Start accepted in cycle 0; first read issued in cycle 1.
  - rom_q is captured at the end of cycle 1+ROM_LATENCY.
  - data_out_valid first rises in cycle 2+ROM_LATENCY (cycle 4 at defaults).
  - With ready held high, throughput is 1 beat/cycle with no bubbles.
- FIFO and output handshake:
  - data_out / data_out_last are driven from the FIFO head (first-word fall-through, registered storage).
  - The head is stable while valid=1 and ready=0.
  - Simultaneous push and pop on a full FIFO is legal; the credit rule forbids push on full without pop.
  - The FIFO never overflows and never loses a beat.
- data_out_last is set on beats with addr OUT_DEPTH-1 (one per pass).
- Width rules: addr and pass counters are unsigned; the pass counter compares against the latched cfg_repeat-1. No arithmetic on data.

Decomposition:
- Package param_stream_pkg:
  - state enum (IDLE, RUN, DRAIN, FIN).
  - FIFO entry struct (data vector + last).
  - localparam helpers for counter widths.
- Sub-module param_stream_fifo: synchronous FWFT FIFO, parameterised on width and depth, with count output. Instantiated once.

Test Plan:
- OUT_DEPTH=4, cfg_repeat=2, ready=1:
  - 8 beats carrying ROM words 0,1,2,3,0,1,2,3.
  - last on beats 4 and 8.
  - first valid in cycle 4 after start.
  - done exactly 1 cycle after the 8th handshake; busy low the cycle after done.
- Same configuration, ready low for cycles 5-12, then high:
  - rom_ce-issued reads stop once FIFO_DEPTH beats are held or in flight.
  - No data is lost or duplicated; the sequence matches the previous test.
- cfg_repeat=0:
  - done pulses the cycle after start.
  - data_out_valid never rises; rom_ce stays 0.
- start held high through a job:
  - Only one job runs.
  - A new job is accepted only in IDLE after done.
- Reset asserted mid-RUN with 3 beats buffered:
  - Next cycle: valid=0, busy=0, done=0, rom_ce=0.
  - A subsequent start restarts from addr 0.
- Random ready toggling (50%), OUT_DEPTH=32, cfg_repeat=3:
  - Scoreboard sees 96 beats in order.
  - Exactly 3 last flags and 1 done pulse.
